// File: rtl/display_pkg.sv
// Shared types and default parameters for the multiplexed seven-segment scan controller.
package display_pkg;

  localparam int DEF_NUM_DIGITS   = 4;
  localparam int DEF_REFRESH_DIV  = 50000;
  localparam int DEF_BLANK_CYCLES = 16;

  typedef logic [3:0] nibble_t;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/display_slot_timer.sv
// Free-running per-slot counter with terminal-count strobes for the scan FSM.
module display_slot_timer
  import display_pkg::*;
#(
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  output logic slot_start_o,
  output logic blank_end_o,
  output logic pre_slot_end_o,
  output logic slot_end_o
);

  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign slot_start_o   = (cnt_q == '0);
  assign blank_end_o    = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
  // One cycle ahead of slot_end so registered outputs can land on the last cycle.
  assign pre_slot_end_o = (cnt_q == CNT_W'(REFRESH_DIV - 2));
  assign slot_end_o     = (cnt_q == CNT_W'(REFRESH_DIV - 1));

  assign cnt_d = slot_end_o ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Seven-segment scan controller: frame-coherent shadow register, blank/show slot FSM,
// registered nibble and active-low anode outputs.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              nib_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  scan_state_t state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] stage_q, stage_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pending_q, pending_d;
  nibble_t                 nib_out_q, nib_out_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic                    frame_done_q, frame_done_d;

  logic slot_start, blank_end, pre_slot_end, slot_end, frame_end;

  display_slot_timer #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk            (clk),
    .rst_n          (rst_n),
    .slot_start_o   (slot_start),
    .blank_end_o    (blank_end),
    .pre_slot_end_o (pre_slot_end),
    .slot_end_o     (slot_end)
  );

  assign frame_end = slot_end && (idx_q == LAST_IDX);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    stage_d      = stage_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    nib_out_d    = nib_out_q;
    frame_done_d = pre_slot_end && (idx_q == LAST_IDX);

    case (state_q)
      S_BLANK: begin
        if (slot_start) nib_out_d = shadow_q[{idx_q, 2'b00} +: 4];
        if (blank_end)  state_d = S_SHOW;
      end
      S_SHOW: begin
        if (slot_end) begin
          state_d = S_BLANK;
          idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: state_d = S_BLANK;
    endcase

    if (load) begin
      stage_d   = value;
      pending_d = 1'b1;
    end

    // A load on the boundary cycle itself is forwarded straight into the shadow copy.
    if (frame_end) begin
      if (load)           shadow_d = value;
      else if (pending_q) shadow_d = stage_q;
      pending_d = 1'b0;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
    assign an_n_d[gi] = !((state_d == S_SHOW) && (idx_d == IDX_W'(gi)) && digit_en[gi]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_BLANK;
      idx_q        <= '0;
      stage_q      <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      nib_out_q    <= '0;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      stage_q      <= stage_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      nib_out_q    <= nib_out_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign nib_out    = nib_out_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Time-multiplexing scan controller for a multi-digit common-anode seven-segment display that shares one 4-bit-to-segment decoder among all digits. It holds a frame-coherent shadow copy of the displayed value and steps through the digits at a fixed refresh rate. It drives the decoder's 4-bit input and the active-low digit anodes. A dead-time interval precedes each digit slot so that a segment pattern never shows on the wrong digit (ghosting).

## Interface

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (≥2)
- REFRESH_DIV, 50000, clock cycles per digit slot (≥4)
- BLANK_CYCLES, 16, dead-time cycles at the start of each slot (1 ≤ BLANK_CYCLES < REFRESH_DIV)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- value  in  4*NUM_DIGITS  hex digits to display; digit i = value[4i+3:4i]
- load  in  1  one-cycle strobe; captures value for display at the next frame boundary
- digit_en  in  NUM_DIGITS  per-digit enable; 0 keeps that anode off for its slot
- nib_out  out  4  nibble to the decoder
- an_n  out  NUM_DIGITS  active-low anode selects; at most one bit low at a time
- frame_done  out  1  one-cycle pulse on the last cycle of each frame

## Operation

- FSM states: S_BLANK, S_SHOW. Registers: slot counter `cnt` of width $clog2(REFRESH_DIV), digit index `idx`, `stage`, `shadow`, `pending`.
- S_BLANK:
  - an_n all ones.
  - nib_out <= shadow nibble of idx, registered on the first blank cycle.
  - After BLANK_CYCLES cycles, go to S_SHOW.
- S_SHOW:
  - an_n[idx] = ~digit_en[idx]; all other bits are 1.
  - After REFRESH_DIV-BLANK_CYCLES cycles, go to S_BLANK with idx+1.
  - idx wraps from NUM_DIGITS-1 to 0.
- A disabled digit still consumes its full slot, so refresh timing does not depend on digit_en. digit_en is sampled every cycle.
- Load path:
  - load=1: stage <= value, pending <= 1.
  - Several loads in one frame: the last one wins.
- Frame boundary is the last cycle of digit NUM_DIGITS-1's S_SHOW. On that edge:
  - If load=1: shadow <= value (forwarded).
  - Else if pending=1: shadow <= stage.
  - pending <= 0 in both cases.
  - frame_done=1 for that cycle only.
- The displayed content never changes within a frame (no tearing).
- Reset values: state S_BLANK, cnt 0, idx 0, an_n all ones, nib_out 0, frame_done 0, stage 0, shadow 0, pending 0.
- Reset mid-operation: an_n goes to all ones asynchronously on rst_n falling. Any pending load is discarded.

## Timing

- All outputs are registered. No combinational path from inputs to outputs.
- Slot length is exactly REFRESH_DIV cycles: BLANK_CYCLES blank, then REFRESH_DIV-BLANK_CYCLES shown.
- Frame length is exactly NUM_DIGITS*REFRESH_DIV cycles.
- After rst_n deasserts, the first anode goes low on the clock edge ending cycle BLANK_CYCLES.
- nib_out changes only while an_n is all ones.
- A load in frame k is visible from the first slot of frame k+1. Worst-case latency is one frame plus BLANK_CYCLES.

## Structure

- Shared package display_pkg holds:
  - scan_state_t enum (S_BLANK, S_SHOW)
  - localparams for default NUM_DIGITS and REFRESH_DIV
  - a nibble_t typedef (logic [3:0])
- One natural sub-module, display_slot_timer, contains the counter plus the blank_end and slot_end terminal-count strobes.
- The seven-segment decoder is instantiated beside this block at the top level, not inside it.

## Test plan

All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset:
  - Hold rst_n=0 for 5 cycles: an_n=4'hF, nib_out=0, frame_done=0 throughout.
  - After release: an_n=4'hE during cycles 2–7, 4'hF during cycles 8–9, 4'hD from cycle 10.
- Frame-coherent load:
  - Load 16'h1234 at cycle 5 of frame 0: all digits show 0 for the rest of frame 0.
  - Frame 1 shows 4, 3, 2, 1 on digits 0–3.
  - frame_done pulses at cycles 31 and 63.
- Load on boundary: load 16'hABCD exactly on cycle 31 → frame 1 shows D, C, B, A.
- Multiple loads: load 16'h1111 then 16'h2222 in the same frame → next frame shows all 2s.
- Digit enables: digit_en=4'b0101 → an_n[1] and an_n[3] stay 1 for all time; frame period stays 32 cycles.
- Reset mid-show: assert rst_n=0 while an_n=4'hB → an_n=4'hF before the next clock edge; after release, scanning restarts at digit 0 showing 0.
